// File: rtl/ccg_bench_driver.sv
// ccg_bench_driver: stimulus/response harness for the CCGRCG combinational benchmarks.
// Drives LFSR patterns onto the benchmark inputs, compacts the responses into a
// 16-bit MISR and compares the final signature against a golden value.
//
// Ports:
//   clk        single clock
//   rst_n      synchronous active-low reset
//   start      run request (honoured in idle/done only)
//   abort      return to idle from run, signature frozen
//   seed_load  load seed_in into the seed register (idle/done only)
//   seed_in    new seed; zero falls back to SEED
//   golden     expected signature, sampled on the final capture edge
//   x          vector driven to the benchmark inputs (bit i -> xi)
//   f          benchmark outputs (bit 0 -> f1), combinational from x
//   busy       high while running
//   done       high once a run has completed
//   pass       signature matched golden (valid while done)
//   signature  MISR contents
//   pat_idx    index of the pattern currently on x
module ccg_bench_driver #(
    parameter int unsigned     IN_W        = 27,
    parameter int unsigned     OUT_W       = 11,
    parameter logic [IN_W-1:0] SEED        = 27'h0000001,
    parameter int unsigned     PATTERN_CNT = 1024,
    parameter int unsigned     SETTLE      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             seed_load,
    input  logic [IN_W-1:0]  seed_in,
    input  logic [15:0]      golden,
    output logic [IN_W-1:0]  x,
    input  logic [OUT_W-1:0] f,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      signature,
    output logic [15:0]      pat_idx
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [1:0]  HoldMax = 2'(SETTLE);
    localparam logic [15:0] LastIdx = 16'(PATTERN_CNT - 1);

    state_e          state_q;
    logic [IN_W-1:0] lfsr_q;
    logic [IN_W-1:0] seed_q;
    logic [15:0]     misr_q;
    logic [15:0]     pat_idx_q;
    logic [1:0]      hold_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;

    logic [IN_W-1:0] lfsr_next;
    logic [15:0]     misr_next;
    logic [IN_W-1:0] seed_eff;

    always_comb begin
        // x^27 + x^5 + x^2 + x + 1
        lfsr_next = {lfsr_q[IN_W-2:0], lfsr_q[IN_W-1] ^ lfsr_q[4] ^ lfsr_q[1] ^ lfsr_q[0]};
        // x^16 + x^15 + x^13 + x^4 + 1, response folded into the low bits
        misr_next = {misr_q[14:0], misr_q[15] ^ misr_q[14] ^ misr_q[12] ^ misr_q[3]}
                    ^ 16'(f);
        // A load in the same cycle as start must seed the run it launches.
        seed_eff = seed_q;
        if (seed_load) begin
            seed_eff = (seed_in == '0) ? SEED : seed_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            lfsr_q    <= SEED;
            seed_q    <= SEED;
            misr_q    <= '0;
            pat_idx_q <= '0;
            hold_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    seed_q <= seed_eff;
                    if (start) begin
                        state_q   <= StRun;
                        lfsr_q    <= seed_eff;
                        misr_q    <= '0;
                        pat_idx_q <= '0;
                        hold_q    <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                    end
                end
                StRun: begin
                    if (abort) begin
                        state_q <= StIdle;
                        hold_q  <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else if (hold_q != HoldMax) begin
                        hold_q <= hold_q + 2'd1;
                    end else begin
                        // Capture edge: f has had SETTLE+1 cycles to settle.
                        misr_q    <= misr_next;
                        lfsr_q    <= lfsr_next;
                        pat_idx_q <= pat_idx_q + 16'd1;
                        hold_q    <= '0;
                        if (pat_idx_q == LastIdx) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (misr_next == golden);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign x         = lfsr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = misr_q;
    assign pat_idx   = pat_idx_q;

endmodule

// File: tb/tb_ccg_bench_driver.sv
// Testbench for ccg_bench_driver: three instances with different pattern counts
// and settle times run in lockstep; every cycle of every run is compared against
// a transaction-level model derived from the LFSR/MISR recurrences.
module tb_ccg_bench_driver;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        abort;
    logic        seed_load;
    logic [26:0] seed_in;
    logic [1:0]  f_mode;
    logic        start_w  [NDUT];
    logic [15:0] golden_w [NDUT];
    logic [26:0] x_w      [NDUT];
    logic [10:0] f_w      [NDUT];
    logic        busy_w   [NDUT];
    logic        done_w   [NDUT];
    logic        pass_w   [NDUT];
    logic [15:0] sig_w    [NDUT];
    logic [15:0] pat_w    [NDUT];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [26:0] cur_seed;

    always #5 clk = ~clk;

    // Stand-in benchmark: constant-0, constant-all-ones, or an xor mix of x.
    function automatic logic [10:0] bench_f(input logic [26:0] v, input logic [1:0] m);
        case (m)
            2'd0:    return 11'h000;
            2'd1:    return 11'h7FF;
            default: return v[10:0] ^ v[21:11] ^ {v[26:22], v[5:0]};
        endcase
    endfunction

    function automatic int cnt_of(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 3 : 1);
    endfunction

    function automatic int settle_of(input int d);
        return (d == 1) ? 2 : 0;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        ccg_bench_driver #(
            .IN_W       (27),
            .OUT_W      (11),
            .SEED       (27'h0000001),
            .PATTERN_CNT((g == 0) ? 4 : ((g == 1) ? 3 : 1)),
            .SETTLE     ((g == 1) ? 2 : 0)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start_w[g]),
            .abort    (abort),
            .seed_load(seed_load),
            .seed_in  (seed_in),
            .golden   (golden_w[g]),
            .x        (x_w[g]),
            .f        (f_w[g]),
            .busy     (busy_w[g]),
            .done     (done_w[g]),
            .pass     (pass_w[g]),
            .signature(sig_w[g]),
            .pat_idx  (pat_w[g])
        );
        assign f_w[g] = bench_f(x_w[g], f_mode);
    end

    function automatic logic [26:0] lfsr_adv(input logic [26:0] v);
        return {v[25:0], v[26] ^ v[4] ^ v[1] ^ v[0]};
    endfunction

    function automatic logic [26:0] vec_at(input logic [26:0] seed, input int k);
        logic [26:0] v = seed;
        for (int i = 0; i < k; i++) v = lfsr_adv(v);
        return v;
    endfunction

    // Signature after k patterns have been captured.
    function automatic logic [15:0] sig_after(input logic [26:0] seed, input int k,
                                              input logic [1:0] m);
        logic [26:0] v = seed;
        logic [15:0] s = 16'h0;
        for (int i = 0; i < k; i++) begin
            s = {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]} ^ {5'b0, bench_f(v, m)};
            v = lfsr_adv(v);
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset();
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst d%0d x", d), 32'(x_w[d]), 32'h1);
            check($sformatf("rst d%0d busy", d), 32'(busy_w[d]), 32'h0);
            check($sformatf("rst d%0d done", d), 32'(done_w[d]), 32'h0);
            check($sformatf("rst d%0d pass", d), 32'(pass_w[d]), 32'h0);
            check($sformatf("rst d%0d sig", d), 32'(sig_w[d]), 32'h0);
            check($sformatf("rst d%0d pat", d), 32'(pat_w[d]), 32'h0);
        end
    endtask

    // Interval c is the c-th cycle after the start edge.
    task automatic check_interval(input int d, input int c, input logic [26:0] seed,
                                  input int acyc);
        int   n = cnt_of(d);
        int   s = settle_of(d);
        int   t = n * (s + 1);
        int   k;
        logic eb, ed, ep;
        if (acyc >= 0 && acyc < t && c > acyc) begin
            k = acyc / (s + 1); eb = 0; ed = 0; ep = 0;
        end else if (c < t) begin
            k = c / (s + 1); eb = 1; ed = 0; ep = 0;
        end else begin
            k = n; eb = 0; ed = 1;
            ep = (sig_after(seed, n, f_mode) == golden_w[d]);
        end
        check($sformatf("d%0d c%0d x", d, c), 32'(x_w[d]), 32'(vec_at(seed, k)));
        check($sformatf("d%0d c%0d pat", d, c), 32'(pat_w[d]), 32'(k));
        check($sformatf("d%0d c%0d sig", d, c), 32'(sig_w[d]), 32'(sig_after(seed, k, f_mode)));
        check($sformatf("d%0d c%0d busy", d, c), 32'(busy_w[d]), 32'(eb));
        check($sformatf("d%0d c%0d done", d, c), 32'(done_w[d]), 32'(ed));
        check($sformatf("d%0d c%0d pass", d, c), 32'(pass_w[d]), 32'(ep));
    endtask

    // One run on all instances. gx flips golden bits per instance (0 = exact golden).
    task automatic do_run(input logic ld, input logic [26:0] ld_val, input int acyc,
                          input bit start_noise, input bit load_noise, input logic [47:0] gx);
        logic [26:0] seed;
        if (ld) cur_seed = (ld_val == '0) ? 27'h1 : ld_val;
        seed = cur_seed;
        for (int d = 0; d < NDUT; d++) begin
            golden_w[d] = sig_after(seed, cnt_of(d), f_mode) ^ gx[d*16 +: 16];
            start_w[d]  = 1'b1;
        end
        seed_load = ld;
        seed_in   = ld_val;
        @(posedge clk); #1;
        seed_load = 1'b0;
        for (int d = 0; d < NDUT; d++) start_w[d] = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            abort = (c == acyc);
            // Every instance is still running in interval 0, so a load here must be ignored.
            seed_load = load_noise && (c == 0);
            seed_in   = 27'($urandom);
            for (int d = 0; d < NDUT; d++) begin
                start_w[d] = start_noise && ($urandom_range(0, 1) == 0)
                             && (c < cnt_of(d) * (settle_of(d) + 1))
                             && (acyc < 0 || c <= acyc);
                check_interval(d, c, seed, acyc);
            end
            @(posedge clk); #1;
        end
        abort     = 1'b0;
        seed_load = 1'b0;
        for (int d = 0; d < NDUT; d++) start_w[d] = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        abort     = 1'b0;
        seed_load = 1'b0;
        seed_in   = '0;
        f_mode    = 2'd2;
        cur_seed  = 27'h1;
        for (int d = 0; d < NDUT; d++) begin
            start_w[d]  = 1'b0;
            golden_w[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        rst_n = 1'b1;

        // Default seed, mixed response.
        do_run(1'b0, '0, -1, 1'b0, 1'b0, 48'h0);

        // All-ones response on a single pattern: signature 0x07FF, pass then fail.
        f_mode = 2'd1;
        do_run(1'b0, '0, -1, 1'b0, 1'b0, 48'h0);
        check("ones sig", 32'(sig_w[2]), 32'h07FF);
        check("ones pass", 32'(pass_w[2]), 32'h1);
        do_run(1'b0, '0, -1, 1'b0, 1'b0, {16'h0001, 32'h0});
        check("ones golden-1 pass", 32'(pass_w[2]), 32'h0);

        // Zero response keeps the signature at zero.
        f_mode = 2'd0;
        do_run(1'b0, '0, -1, 1'b0, 1'b0, 48'h0);
        check("zero sig", 32'(sig_w[0]), 32'h0);

        // Seed loads: zero falls back to SEED; load together with start; loads in RUN ignored.
        f_mode = 2'd2;
        do_run(1'b1, 27'h0, -1, 1'b0, 1'b0, 48'h0);
        do_run(1'b1, 27'h5A5A5A, -1, 1'b0, 1'b1, 48'h0);
        do_run(1'b0, '0, -1, 1'b0, 1'b0, 48'h0);
        seed_load = 1'b1;
        seed_in   = 27'h123_4567;
        @(posedge clk); #1;
        seed_load = 1'b0;
        cur_seed  = 27'h123_4567;
        do_run(1'b0, '0, -1, 1'b0, 1'b0, 48'h0);

        // Abort at pat_idx 2 of the settled instance, with start pulses during RUN.
        do_run(1'b0, '0, 6, 1'b1, 1'b0, 48'h0);
        do_run(1'b0, '0, -1, 1'b1, 1'b0, 48'h0);

        // Reset mid-run restores everything, including the seed register.
        seed_load = 1'b1;
        seed_in   = 27'h5A5A5A;
        for (int d = 0; d < NDUT; d++) start_w[d] = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        for (int d = 0; d < NDUT; d++) start_w[d] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset();
        rst_n    = 1'b1;
        cur_seed = 27'h1;
        do_run(1'b0, '0, -1, 1'b0, 1'b0, 48'h0);

        // Randomised runs.
        for (int r = 0; r < 14; r++) begin
            logic        ld;
            logic [26:0] sv;
            logic [47:0] gx;
            int          ac;
            f_mode = 2'($urandom_range(0, 2));
            ld     = 1'($urandom_range(0, 1));
            sv     = ($urandom_range(0, 3) == 0) ? 27'h0 : 27'($urandom);
            gx     = '0;
            for (int d = 0; d < NDUT; d++) begin
                if ($urandom_range(0, 1) == 1) gx[d*16 +: 16] = 16'($urandom_range(1, 65535));
            end
            ac = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 9)) : -1;
            do_run(ld, sv, ac, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), gx);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
